// File: rtl/acc_writeback_unit.sv
// Snapshot, requantize and stream the PE accumulator array to memory as packed 2x16-bit words.
// Optional macro RELU_EN: clamp negative rounded results to zero before saturation.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; snapshot bank holds last captured array
// S_WRITE | presenting word k on the req/ack port, advancing on each ack
// S_DONE  | one-cycle done pulse, then back to idle
module acc_writeback_unit #(
  parameter int activation_width  = 16,
  parameter int accumulator_width = 40,
  parameter int array_x           = 4,
  parameter int array_y           = 4
) (
  input  logic                                           clk,
  input  logic                                           rstn,
  input  logic                                           start,
  input  logic [15:0]                                    out_base_addr,
  input  logic [4:0]                                     shift,
  input  logic [array_x*array_y*accumulator_width-1:0]   acc_flat,
  output logic                                           mem_write_req,
  output logic [31:0]                                    mem_write_addr,
  output logic [31:0]                                    mem_write_data,
  input  logic                                           mem_write_ack,
  output logic                                           busy,
  output logic                                           done
);

  localparam int n_elem = array_x * array_y;
  localparam int n_word = (n_elem + 1) / 2;
  localparam int kw     = (n_word > 1) ? $clog2(n_word) : 1;

  localparam logic signed [accumulator_width:0] sat_max =
    (accumulator_width+1)'((1 << (activation_width - 1)) - 1);
  localparam logic signed [accumulator_width:0] sat_min = ~sat_max;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t                               state;
  logic signed [accumulator_width-1:0]  snap [n_elem];
  logic [4:0]                           shift_q;
  logic [15:0]                          base_q;
  logic [kw-1:0]                        k;

  logic [kw-1:0] nk;
  logic [kw:0]   lo_idx;
  logic [kw:0]   hi_idx;
  logic [31:0]   next_word;

  function automatic logic [15:0] requant(input logic signed [accumulator_width-1:0] a,
                                          input logic [4:0] sh);
    logic signed [accumulator_width:0]  r;
    logic signed [accumulator_width:0]  bias;
    logic signed [activation_width-1:0] sat;
    r    = {a[accumulator_width-1], a};
    bias = '0;
    if (sh != 5'd0) begin
      bias = (accumulator_width+1)'(1) << (sh - 5'd1);
      r    = r + bias;
      r    = r >>> sh;
    end
`ifdef RELU_EN
    if (r < 0) r = '0;
`endif
    if (r > sat_max)      sat = sat_max[activation_width-1:0];
    else if (r < sat_min) sat = sat_min[activation_width-1:0];
    else                  sat = r[activation_width-1:0];
    return 16'(sat);
  endfunction

  // Word to load on the next register update: k on entry to WRITE, k+1 after an ack.
  always_comb begin
    nk        = mem_write_req ? k + kw'(1) : k;
    lo_idx    = {nk, 1'b0};
    hi_idx    = {nk, 1'b1};
    next_word = '0;
    if (int'(lo_idx) < n_elem) next_word[15:0]  = requant(snap[lo_idx], shift_q);
    if (int'(hi_idx) < n_elem) next_word[31:16] = requant(snap[hi_idx], shift_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_IDLE;
      shift_q        <= '0;
      base_q         <= '0;
      k              <= '0;
      mem_write_req  <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      for (int i = 0; i < n_elem; i++) snap[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < n_elem; i++)
              snap[i] <= acc_flat[i*accumulator_width +: accumulator_width];
            base_q  <= out_base_addr;
            shift_q <= shift;
            k       <= '0;
            busy    <= 1'b1;
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          // First cycle in WRITE only loads word 0 from the freshly captured snapshot.
          if (!mem_write_req) begin
            mem_write_req  <= 1'b1;
            mem_write_addr <= {16'h0000, base_q};
            mem_write_data <= next_word;
          end else if (mem_write_ack) begin
            if (k == kw'(n_word - 1)) begin
              mem_write_req <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
              state         <= S_DONE;
            end else begin
              k              <= nk;
              mem_write_addr <= mem_write_addr + 32'd4;
              mem_write_data <= next_word;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/acc_writeback_unit.md
Name: acc_writeback_unit

Overview:
Downstream neighbour of the conv compute controller; implements its WRITEBACK phase. On start, snapshots the full PE accumulator array and requantizes each accumulator to activation width (shift, round, saturate). Packs two results per 32-bit word and streams the words to memory over the req/ack write port, then pulses done.

Parameters:
activation_width, 16, output element width; must be <=16; each result is sign-extended into a 16-bit lane.
accumulator_width, 40, PE accumulator width; must be >= activation_width+1.
array_x, 4, PE array rows.
array_y, 4, PE array columns.

Ports:
clk  input  1  clock; all logic on the rising edge.
rstn  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to capture and write back; honoured only in IDLE.
out_base_addr  input  16  byte address of the first output word; sampled at start.
shift  input  5  arithmetic right-shift amount for requantization; sampled at start.
acc_flat  input  array_x*array_y*accumulator_width  flattened accumulators; element (x,y) at bits [(x*array_y+y)*accumulator_width +: accumulator_width]; signed.
mem_write_req  output  1  write request.
mem_write_addr  output  32  byte address of the current word.
mem_write_data  output  32  packed word.
mem_write_ack  input  1  memory accepts the current word.
busy  output  1  high from the cycle after start until done.
done  output  1  one-cycle pulse after the last write is acknowledged.

Behaviour:
- Reset: all outputs 0; state IDLE; snapshot and counters cleared. Reset mid-operation aborts at once: req drops, no done pulse, snapshot discarded.
- States: IDLE, WRITE, DONE.
- IDLE: on start=1, register acc_flat into the snapshot bank, latch out_base_addr and shift, clear word index k, set busy=1, go to WRITE. Other inputs are ignored.
- N = array_x*array_y elements, flat index i = x*array_y+y. W = ceil(N/2) words. Word k has element 2k in bits [15:0] and element 2k+1 in bits [31:16]. If N is odd, the upper lane of the last word is 0.
- Requant per element:
  - if shift>0, r = (a + 2^(shift-1)) >>> shift, computed at accumulator_width+1 bits so there is no overflow; if shift=0, r = a.
  - Saturate r to signed activation_width: max 2^(aw-1)-1, min -2^(aw-1).
  - Sign-extend the result to 16 bits.
- WRITE:
  - mem_write_req=1, mem_write_addr = zero-extended out_base_addr + 4*k (32-bit, wraps mod 2^32), data = word k. All are registered outputs.
  - req/addr/data stay stable until a cycle with mem_write_ack=1. In that cycle the word is transferred.
  - If k<W-1: k increments and the next word is presented the following cycle; req stays high, with no idle bubble.
  - If k=W-1: go to DONE, and req drops the following cycle.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE. A start arriving in the same cycle as done is ignored.
- mem_write_ack while req=0 is ignored.
- start while busy is ignored. acc_flat changes after capture have no effect.
- Latency: start sampled at edge 0 -> req=1 after edge 1. With ack held high: W words take W cycles, done is high the cycle after the last ack, total W+2 cycles start-to-done.
- Writes always complete in order k=0..W-1. There is no timeout.

Optional Feature:
RELU_EN
- Defined: after rounding and before saturation, r<0 is replaced by 0, so every lane is in [0, 2^(aw-1)-1].
- Not defined: signed saturation only, as above. The interface is identical in both cases.

Test Plan:
- All acc=100, shift=0, base=0x0100, ack tied 1 -> 8 writes, addr 0x100..0x11C step 4, data 0x00640064 each; done on the 10th cycle after start; busy high for cycles 1..9.
- acc(0,0)=7, acc(0,1)=-7, shift=1 -> word0=0xFFFD0004 (7 -> 4, -7 -> -3 under round-half-up).
- acc(0,0)=2^20, acc(0,1)=-2^20, shift=0 -> word0=0x80007FFF. With RELU_EN -> 0x00007FFF.
- Ack delayed 3 cycles per word, acc_flat randomized after start -> addr/data held stable while waiting; data matches the start-time snapshot.
- start pulsed during WRITE, then rstn pulled low after 2 acks -> no restart; all outputs 0 immediately; no done; a fresh start then writes all 8 words from k=0.
- Ack pulses while idle, and start in the done cycle -> no req, no state change.
